// File: rtl/zigbee_cordic_pkg.sv
// Shared types and constants for the Zigbee CORDIC rotator.
// Holds the FSM state type, the CORDIC gain constant and the arctangent generator.
package zigbee_cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam real CORDIC_GAIN_INV = 0.607253;
  localparam real CORDIC_PI       = 3.14159265358979323846;

  // round(atan(2^-i) * 2^(w-1) / pi), evaluated at elaboration only
  function automatic int atan_const(input int i, input int w);
    real a;
    a = $atan(1.0 / (2.0 ** i)) * (2.0 ** (w - 1)) / CORDIC_PI;
    return $rtoi(a + 0.5);
  endfunction

endpackage

// File: rtl/zigbee_cordic_rot_step.sv
// One combinational CORDIC micro-rotation with a variable arithmetic shift.
// The rotation direction follows the sign of the residual angle.
module zigbee_cordic_rot_step #(
  parameter int XY_SIZE = 16,
  parameter int W_SIZE  = 16,
  parameter int SH_W    = 4
) (
  input  logic signed [XY_SIZE-1:0] i_x,
  input  logic signed [XY_SIZE-1:0] i_y,
  input  logic signed [W_SIZE-1:0]  i_z,
  input  logic        [SH_W-1:0]    i_shift,
  input  logic signed [W_SIZE-1:0]  i_atan,
  output logic signed [XY_SIZE-1:0] o_x,
  output logic signed [XY_SIZE-1:0] o_y,
  output logic signed [W_SIZE-1:0]  o_z
);

  logic signed [XY_SIZE-1:0] w_xs;
  logic signed [XY_SIZE-1:0] w_ys;
  logic                      w_pos;

  assign w_xs  = i_x >>> i_shift;
  assign w_ys  = i_y >>> i_shift;
  assign w_pos = ~i_z[W_SIZE-1];

  assign o_x = w_pos ? (i_x - w_ys) : (i_x + w_ys);
  assign o_y = w_pos ? (i_y + w_xs) : (i_y - w_xs);
  assign o_z = w_pos ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/zigbee_cordic_rotator.sv
// Iterative rotation-mode CORDIC: binary phase in, scaled (cos, sin) out, one step per clock.
// Optional macro ZIGBEE_CORDIC_ROT_RESIDUAL_EN exposes the final angle residual as out_resid.
module zigbee_cordic_rotator
  import zigbee_cordic_pkg::*;
#(
  parameter int XY_SIZE   = 16,
  parameter int W_SIZE    = 16,
  parameter int N_ITER    = 14,
  parameter int GAIN_COMP = $rtoi(CORDIC_GAIN_INV * (2.0 ** (XY_SIZE - 2)) + 0.5)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [W_SIZE-1:0]  in_angle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [XY_SIZE-1:0] out_cos,
  output logic signed [XY_SIZE-1:0] out_sin
`ifdef ZIGBEE_CORDIC_ROT_RESIDUAL_EN
  ,
  output logic signed [W_SIZE-1:0]  out_resid
`endif
);

  // state | meaning: IDLE waits for an angle; ROTATE does one micro-rotation per clock; DONE holds the result
  localparam int CNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic signed [XY_SIZE-1:0] GAIN_POS = XY_SIZE'(GAIN_COMP);
  localparam logic signed [XY_SIZE-1:0] GAIN_NEG = XY_SIZE'(-GAIN_COMP);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [XY_SIZE-1:0] r_x;
  logic signed [XY_SIZE-1:0] r_y;
  logic signed [W_SIZE-1:0]  r_z;
  logic        [CNT_W-1:0]   r_cnt;
  logic signed [XY_SIZE-1:0] w_x_step;
  logic signed [XY_SIZE-1:0] w_y_step;
  logic signed [W_SIZE-1:0]  w_z_step;
  logic signed [W_SIZE-1:0]  w_atan_tab [N_ITER];
  logic                      w_accept;
  logic                      w_fold;
  logic                      w_last;

  for (genvar g = 0; g < N_ITER; g++) begin : g_atan
    assign w_atan_tab[g] = W_SIZE'(atan_const(g, W_SIZE));
  end

  assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  // angles in the left half-plane are rotated by pi and start from a negated X
  assign w_fold   = in_angle[W_SIZE-1] ^ in_angle[W_SIZE-2];
  assign w_last   = (r_cnt == CNT_W'(N_ITER - 1));

  zigbee_cordic_rot_step #(
    .XY_SIZE (XY_SIZE),
    .W_SIZE  (W_SIZE),
    .SH_W    (CNT_W)
  ) u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_cnt),
    .i_atan  (w_atan_tab[r_cnt]),
    .o_x     (w_x_step),
    .o_y     (w_y_step),
    .o_z     (w_z_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_ROTATE;
      ST_ROTATE: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept)       w_state_nxt = ST_ROTATE;
        else if (out_ready) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x   <= w_fold ? GAIN_NEG : GAIN_POS;
        r_y   <= '0;
        r_z   <= {in_angle[W_SIZE-1] ^ w_fold, in_angle[W_SIZE-2:0]};
        r_cnt <= '0;
      end else if (r_state == ST_ROTATE) begin
        r_x   <= w_x_step;
        r_y   <= w_y_step;
        r_z   <= w_z_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign out_cos   = out_valid ? r_x : '0;
  assign out_sin   = out_valid ? r_y : '0;
`ifdef ZIGBEE_CORDIC_ROT_RESIDUAL_EN
  assign out_resid = out_valid ? r_z : '0;
`endif

endmodule

// File: tb/tb_zigbee_cordic_rotator.sv
// Directed-vector and random-sweep bench for zigbee_cordic_rotator (default parameters).
module tb_zigbee_cordic_rotator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] in_angle = '0;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_cos;
  logic signed [15:0] out_sin;
`ifdef ZIGBEE_CORDIC_ROT_RESIDUAL_EN
  logic signed [15:0] out_resid;
`endif

  always #5 clk = ~clk;

  zigbee_cordic_rotator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin)
`ifdef ZIGBEE_CORDIC_ROT_RESIDUAL_EN
    ,
    .out_resid (out_resid)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // hand-computed round(atan(2^-i) * 32768 / pi)
  logic signed [15:0] atab [14] = '{16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651,
                                    16'sd326, 16'sd163, 16'sd81, 16'sd41, 16'sd20,
                                    16'sd10, 16'sd5, 16'sd3, 16'sd1};

  typedef struct {
    int angle;
    int exp_cos;
    int exp_sin;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_total++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
  endtask

  // bit-exact reference of the specified fold + micro-rotation sequence
  function automatic void model(input logic signed [15:0] ang, output int c, output int s);
    logic signed [15:0] x, y, z, xn, yn;
    logic f;
    f = ang[15] ^ ang[14];
    x = f ? -16'sd9949 : 16'sd9949;
    y = '0;
    z = f ? {~ang[15], ang[14:0]} : ang;
    for (int i = 0; i < 14; i++) begin
      if (!z[15]) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - atab[i];
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + atab[i];
      end
      x = xn;
      y = yn;
    end
    c = int'(x);
    s = int'(y);
  endfunction

  // from the negedge after an acceptance edge, count edges until out_valid (bounded)
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_one(input int angle, output int c, output int s, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = 16'(angle);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_angle = ~in_angle;
    wait_result(lat);
    c = int'(out_cos);
    s = int'(out_sin);
    release_out();
  endtask

  initial begin
    int c, s, lat, c0, s0, seen, ra, mc, ms;

    vecs[0] = '{0,       16384,      0};
    vecs[1] = '{8192,    11585,  11585};
    vecs[2] = '{16384,       0,  16384};
    vecs[3] = '{-32768, -16384,      0};
    vecs[4] = '{-16384,      0, -16384};
    vecs[5] = '{-8192,   11585, -11585};
    vecs[6] = '{24576,  -11585,  11585};
    vecs[7] = '{-24576, -11585, -11585};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_cos", int'(out_cos), 0);
    chk("reset_out_sin", int'(out_sin), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      run_one(vecs[k].angle, c, s, lat);
      chk_tol($sformatf("vec%0d_cos", k), c, vecs[k].exp_cos, 4);
      chk_tol($sformatf("vec%0d_sin", k), s, vecs[k].exp_sin, 4);
      chk($sformatf("vec%0d_latency", k), lat, 14);
      chk($sformatf("vec%0d_valid_drop", k), int'(out_valid), 0);
    end

    // backpressure: hold the result, then hand off to a new angle on the same edge
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = 16'sd8192;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp_latency", lat, 14);
    c0 = int'(out_cos);
    s0 = int'(out_sin);
    chk_tol("bp_cos", c0, 11585, 4);
    chk_tol("bp_sin", s0, 11585, 4);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_cos", int'(out_cos), c0);
      chk("bp_hold_sin", int'(out_sin), s0);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_angle  = 16'sd0;
    #1;
    chk("handoff_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("handoff_valid_drop", int'(out_valid), 0);
    wait_result(lat);
    chk("handoff_latency", lat, 14);
    chk_tol("handoff_cos", int'(out_cos), 16384, 4);
    chk_tol("handoff_sin", int'(out_sin), 0, 4);
    release_out();

    // reset in the middle of ROTATE discards the operation
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = 16'sd8192;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_cos", int'(out_cos), 0);
    chk("midrst_out_sin", int'(out_sin), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 0);

    // random sweep against the bit-exact reference, plus boundary angles first
    for (int k = 0; k < 1000; k++) begin
      case (k)
        0:       ra = 32767;
        1:       ra = -32767;
        2:       ra = 16383;
        3:       ra = -16385;
        default: ra = int'($urandom_range(0, 65535)) - 32768;
      endcase
      model(16'(ra), mc, ms);
      run_one(ra, c, s, lat);
      chk($sformatf("rand_cos angle=%0d", ra), c, mc);
      chk($sformatf("rand_sin angle=%0d", ra), s, ms);
      chk($sformatf("rand_latency angle=%0d", ra), lat, 14);
      chk($sformatf("rand_valid_drop angle=%0d", ra), int'(out_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
